contadores_ram_sat: RTL

Parametrised bank of 2^ADDR_W event counters held in a simple dual-port RAM, updated by a two-stage read-modify-write pipeline. This is the successor to the single-step counter RAM. It adds a programmable increment step, saturating or wrapping arithmetic, an overflow flag, hazard forwarding for back-to-back hits, and a sequential clear sweep that replaces a register-wide clear. It sits between the event decoders and the statistics readout logic.

---
 rtl/contadores_pkg.sv | 44 ++++
 rtl/ram_sdp.sv | 22 ++
 rtl/contadores_ram_sat.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/contadores_pkg.sv
// rtl/contadores_pkg.sv - shared types and saturating adder for the counter RAM
package contadores_pkg;

    localparam int MAX_ADDR_W = 16;
    localparam int MAX_CNT_W  = 32;
    localparam logic [MAX_CNT_W:0] SUM_ONE = 1;

    typedef enum logic {SWEEP, IDLE} state_t;

    typedef struct packed {
        logic                  valid;
        logic [MAX_ADDR_W-1:0] addr;
        logic [MAX_CNT_W-1:0]  step;
        logic                  clr;
        logic                  inc;
        logic                  rd;
    } op_t;

    typedef struct packed {
        logic [MAX_CNT_W-1:0] result;
        logic                 ovf;
    } add_t;

    // Sum is one bit wider than the counter so the carry out is the overflow.
    function automatic add_t sat_add(input logic [MAX_CNT_W-1:0] old_val,
                                     input logic [MAX_CNT_W-1:0] step_val,
                                     input int unsigned          cnt_w,
                                     input logic                 saturate);
        logic [MAX_CNT_W:0] sum;
        logic [MAX_CNT_W:0] lim;
        logic [MAX_CNT_W:0] wrapped;
        add_t               r;
        sum     = {1'b0, old_val} + {1'b0, step_val};
        lim     = (SUM_ONE << cnt_w) - SUM_ONE;
        wrapped = sum & lim;
        r.ovf   = (sum > lim);
        if (r.ovf && saturate)
            r.result = lim[MAX_CNT_W-1:0];
        else
            r.result = wrapped[MAX_CNT_W-1:0];
        return r;
    endfunction

endpackage

// File: rtl/ram_sdp.sv
// rtl/ram_sdp.sv - simple dual-port RAM, synchronous read, no read-during-write ordering
module ram_sdp #(
    parameter int ADDR_W = 6,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [CNT_W-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [CNT_W-1:0]  rdata
);

    logic [CNT_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/contadores_ram_sat.sv
// rtl/contadores_ram_sat.sv - RAM counter bank with step, saturation, forwarding and clear sweep
module contadores_ram_sat
    import contadores_pkg::*;
#(
    parameter int ADDR_W   = 6,
    parameter int CNT_W    = 4,
    parameter bit SATURATE = 1'b1
) (
    input  logic              clk,
    input  logic              gen_reset,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] adress,
    input  logic [CNT_W-1:0]  step,
    input  logic              count_reset,
    input  logic              count_read,
    input  logic              clear_all,
    output logic              busy,
    output logic [CNT_W-1:0]  count_out,
    output logic              count_valid,
    output logic              overflow
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t                state;
    logic [ADDR_W-1:0]     sweep_ptr;
    op_t                   req;
    op_t                   s1;
    logic                  s2_wr;
    logic [MAX_ADDR_W-1:0] s2_addr;
    logic [MAX_CNT_W-1:0]  s2_data;
    logic [MAX_CNT_W-1:0]  old_val;
    logic [MAX_CNT_W-1:0]  new_val;
    add_t                  add_res;
    logic                  op_ovf;
    logic                  op_wr;
    logic                  ram_we;
    logic [ADDR_W-1:0]     ram_waddr;
    logic [CNT_W-1:0]      ram_wdata;
    logic [CNT_W-1:0]      ram_rdata;

    // A request coinciding with clear_all is dropped so the sweep owns the write port.
    always_comb begin
        req                   = '0;
        req.valid             = !busy && !clear_all &&
                                (write_enable || count_reset || count_read);
        req.addr[ADDR_W-1:0]  = adress;
        req.step[CNT_W-1:0]   = step;
        req.clr               = count_reset;
        req.inc               = write_enable;
        req.rd                = count_read;
    end

    // The RAM may return stale data for the address written on the same edge.
    always_comb begin
        old_val              = '0;
        old_val[CNT_W-1:0]   = ram_rdata;
        if (s2_wr && (s2_addr == s1.addr))
            old_val = s2_data;
        add_res = sat_add(old_val, s1.step, CNT_W, SATURATE);
        if (s1.clr)
            new_val = '0;
        else if (s1.inc)
            new_val = add_res.result;
        else
            new_val = old_val;
        op_ovf = !s1.clr && s1.inc && add_res.ovf;
        op_wr  = s1.valid && (s1.clr || s1.inc);
    end

    always_comb begin
        ram_we    = (state == SWEEP) || op_wr;
        ram_waddr = (state == SWEEP) ? sweep_ptr : s1.addr[ADDR_W-1:0];
        ram_wdata = (state == SWEEP) ? '0 : new_val[CNT_W-1:0];
    end

    ram_sdp #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (adress),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or posedge gen_reset) begin
        if (gen_reset) begin
            state     <= SWEEP;
            sweep_ptr <= '0;
            busy      <= 1'b1;
        end else begin
            case (state)
                SWEEP: begin
                    if (sweep_ptr == LAST_ADDR) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        sweep_ptr <= '0;
                    end else begin
                        sweep_ptr <= sweep_ptr + 1'b1;
                    end
                end
                IDLE: begin
                    if (clear_all) begin
                        state     <= SWEEP;
                        busy      <= 1'b1;
                        sweep_ptr <= '0;
                    end
                end
                default: begin
                    state <= SWEEP;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge gen_reset) begin
        if (gen_reset) begin
            s1          <= '0;
            s2_wr       <= 1'b0;
            s2_addr     <= '0;
            s2_data     <= '0;
            count_out   <= '0;
            count_valid <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            s1          <= req;
            s2_wr       <= op_wr;
            if (op_wr) begin
                s2_addr <= s1.addr;
                s2_data <= new_val;
            end
            count_valid <= s1.valid && s1.rd;
            overflow    <= s1.valid && op_ovf;
            if (s1.valid && s1.rd)
                count_out <= new_val[CNT_W-1:0];
        end
    end

endmodule
